glyph_blit_ctrl: RTL and testbench

Sequences a combinational 5x5 glyph row ROM (3-bit row index in, 5-bit row pattern out, MSB = leftmost column). Expands one glyph into per-pixel framebuffer write requests at a given origin, colour and integer scale. Sits between the calculator display logic, which issues draw commands, and the VGA framebuffer write port. One glyph draw at a time; the ROM is owned exclusively while busy.

---
 rtl/glyph_blit_ctrl_pkg.sv | 22 ++
 rtl/glyph_scan_counter.sv | 75 +++++++
 rtl/glyph_blit_ctrl.sv | 146 ++++++++++++++
 tb/tb_glyph_blit_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_blit_ctrl_pkg.sv
// Shared types and constants for the glyph blitter: FSM states, glyph
// geometry, colour and row/column index types.
package glyph_blit_ctrl_pkg;

    localparam int GLYPH_W = 5;
    localparam int GLYPH_H = 5;
    localparam int C_W_DEF = 8;
    localparam int ROW_W   = $clog2(GLYPH_H);
    localparam int COL_W   = $clog2(GLYPH_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PIXEL = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [C_W_DEF-1:0] color_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [COL_W-1:0]   col_t;

endpackage

// File: rtl/glyph_scan_counter.sv
// Nested scan counters for glyph expansion: sub-column sx, column c,
// sub-row sy and glyph row r, advancing in that order. Also produces the
// framebuffer offsets of the current pixel relative to the glyph origin.
module glyph_scan_counter
    import glyph_blit_ctrl_pkg::*;
#(
    parameter int GLYPH_W = glyph_blit_ctrl_pkg::GLYPH_W,
    parameter int GLYPH_H = glyph_blit_ctrl_pkg::GLYPH_H,
    parameter int SCALE   = 1,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           clear_sub,
    input  logic           advance,
    output row_t           row,
    output col_t           col,
    output logic           end_subrow,
    output logic           end_row,
    output logic           last_row,
    output logic [X_W-1:0] x_off,
    output logic [Y_W-1:0] y_off
);

    // Sub-pixel counters need at least one bit even when SCALE is 1.
    localparam int S_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [S_W-1:0] sx;
    logic [S_W-1:0] sy;
    col_t           c;
    row_t           r;

    assign row        = r;
    assign col        = c;
    assign end_subrow = (c == col_t'(GLYPH_W - 1)) && (sx == S_W'(SCALE - 1));
    assign end_row    = end_subrow && (sy == S_W'(SCALE - 1));
    assign last_row   = (r == row_t'(GLYPH_H - 1));
    assign x_off      = X_W'(c) * X_W'(SCALE) + X_W'(sx);
    assign y_off      = Y_W'(r) * Y_W'(SCALE) + Y_W'(sy);

    // Clear on a new glyph, clear the in-row counters on each fetch,
    // otherwise ripple sx -> c -> sy -> r on every advance.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sx <= '0;
            c  <= '0;
            sy <= '0;
            r  <= '0;
        end else if (clear_sub) begin
            sx <= '0;
            c  <= '0;
            sy <= '0;
        end else if (advance) begin
            if (sx != S_W'(SCALE - 1)) begin
                sx <= sx + 1'b1;
            end else begin
                sx <= '0;
                if (c != col_t'(GLYPH_W - 1)) begin
                    c <= c + 1'b1;
                end else begin
                    c <= '0;
                    if (sy != S_W'(SCALE - 1)) begin
                        sy <= sy + 1'b1;
                    end else begin
                        sy <= '0;
                        r  <= r + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/glyph_blit_ctrl.sv
// Glyph blit controller: fetches each glyph row from an external
// combinational ROM and expands it into per-pixel framebuffer writes at
// the captured origin, colours and integer scale.
module glyph_blit_ctrl #(
    parameter int GLYPH_W = glyph_blit_ctrl_pkg::GLYPH_W,
    parameter int GLYPH_H = glyph_blit_ctrl_pkg::GLYPH_H,
    parameter int SCALE   = 1,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int C_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [C_W-1:0]     fg,
    input  logic [C_W-1:0]     bg,
    input  logic               transparent,
    output logic               busy,
    output logic               done,
    output logic [2:0]         rom_row,
    input  logic [GLYPH_W-1:0] rom_code,
    output logic               wr_req,
    output logic [X_W-1:0]     wr_x,
    output logic [Y_W-1:0]     wr_y,
    output logic [C_W-1:0]     wr_color,
    input  logic               wr_ack
);

    import glyph_blit_ctrl_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [X_W-1:0]   x0_q;
    logic [Y_W-1:0]   y0_q;
    logic [C_W-1:0]   fg_q;
    logic [C_W-1:0]   bg_q;
    logic             transp_q;
    logic [GLYPH_W-1:0] row_buf;

    row_t             row;
    col_t             col;
    logic             end_subrow;
    logic             end_row;
    logic             last_row;
    logic [X_W-1:0]   x_off;
    logic [Y_W-1:0]   y_off;

    logic             accept;
    logic             pix_bit;
    logic             need_wr;
    logic             advance;

    assign accept  = (state_q == IDLE) && start;
    assign pix_bit = row_buf[col_t'(GLYPH_W - 1) - col];
    assign need_wr = pix_bit || !transp_q;
    // Skipped pixels advance unconditionally; written pixels wait for ack.
    assign advance = (state_q == PIXEL) && (!need_wr || wr_ack);

    glyph_scan_counter #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .SCALE   (SCALE),
        .X_W     (X_W),
        .Y_W     (Y_W)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .clear_sub  (state_q == FETCH),
        .advance    (advance),
        .row        (row),
        .col        (col),
        .end_subrow (end_subrow),
        .end_row    (end_row),
        .last_row   (last_row),
        .x_off      (x_off),
        .y_off      (y_off)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Draw parameters captured on an accepted start; ROM row latched in FETCH.
    always_ff @(posedge clk) begin
        if (accept) begin
            x0_q     <= x0;
            y0_q     <= y0;
            fg_q     <= fg;
            bg_q     <= bg;
            transp_q <= transparent;
        end
        if (state_q == FETCH) begin
            row_buf <= rom_code;
        end
    end

    // Next-state logic and outputs; address/colour only change with the
    // counters, so they hold steady while a write waits for ack.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        rom_row  = '0;
        wr_req   = 1'b0;
        wr_x     = '0;
        wr_y     = '0;
        wr_color = '0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rom_row = 3'(row);
                state_d = PIXEL;
            end
            PIXEL: begin
                wr_req   = need_wr;
                wr_x     = x0_q + x_off;
                wr_y     = y0_q + y_off;
                wr_color = pix_bit ? fg_q : bg_q;
                if (advance && end_row) begin
                    state_d = last_row ? DONE : FETCH;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_glyph_blit_ctrl.sv
// Self-checking bench for glyph_blit_ctrl: diagonal test ROM, expected
// writes queued when each draw is issued and popped as writes are accepted.
module tb_glyph_blit_ctrl;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int C_W = 8;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start;
    logic           sel;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [C_W-1:0] fg;
    logic [C_W-1:0] bg;
    logic           transparent;
    logic           wr_ack;

    logic           busy1, done1, wr_req1;
    logic [2:0]     rom_row1;
    logic [4:0]     rom_code1;
    logic [X_W-1:0] wr_x1;
    logic [Y_W-1:0] wr_y1;
    logic [C_W-1:0] wr_color1;

    logic           busy2, done2, wr_req2;
    logic [2:0]     rom_row2;
    logic [4:0]     rom_code2;
    logic [X_W-1:0] wr_x2;
    logic [Y_W-1:0] wr_y2;
    logic [C_W-1:0] wr_color2;

    logic           m_busy, m_done, m_wr_req;
    logic [X_W-1:0] m_wr_x;
    logic [Y_W-1:0] m_wr_y;
    logic [C_W-1:0] m_wr_color;

    int  tests = 0;
    int  fails = 0;
    wr_t exp_q[$];

    function automatic logic [4:0] rom_model(input logic [2:0] row);
        logic [4:0] one;
        one = 5'b00001;
        return (row < 3'd5) ? (one << (3'd4 - row)) : 5'd0;
    endfunction

    assign rom_code1 = rom_model(rom_row1);
    assign rom_code2 = rom_model(rom_row2);

    glyph_blit_ctrl #(.SCALE(1), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
        .clk(clk), .reset(reset), .start(start && !sel),
        .x0(x0), .y0(y0), .fg(fg), .bg(bg), .transparent(transparent),
        .busy(busy1), .done(done1), .rom_row(rom_row1), .rom_code(rom_code1),
        .wr_req(wr_req1), .wr_x(wr_x1), .wr_y(wr_y1), .wr_color(wr_color1),
        .wr_ack(wr_ack)
    );

    glyph_blit_ctrl #(.SCALE(2), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut2 (
        .clk(clk), .reset(reset), .start(start && sel),
        .x0(x0), .y0(y0), .fg(fg), .bg(bg), .transparent(transparent),
        .busy(busy2), .done(done2), .rom_row(rom_row2), .rom_code(rom_code2),
        .wr_req(wr_req2), .wr_x(wr_x2), .wr_y(wr_y2), .wr_color(wr_color2),
        .wr_ack(wr_ack)
    );

    assign m_busy     = sel ? busy2     : busy1;
    assign m_done     = sel ? done2     : done1;
    assign m_wr_req   = sel ? wr_req2   : wr_req1;
    assign m_wr_x     = sel ? wr_x2     : wr_x1;
    assign m_wr_y     = sel ? wr_y2     : wr_y1;
    assign m_wr_color = sel ? wr_color2 : wr_color1;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Queue every write the draw must produce, in scan order.
    task automatic push_draw(input int ox, input int oy, input logic [7:0] f,
                             input logic [7:0] b, input logic tr, input int scale);
        logic [4:0] bits;
        logic       px;
        wr_t        e;
        for (int r = 0; r < 5; r++) begin
            bits = rom_model(3'(r));
            for (int sy = 0; sy < scale; sy++) begin
                for (int c = 0; c < 5; c++) begin
                    px = bits[4 - c];
                    for (int sx = 0; sx < scale; sx++) begin
                        if (px || !tr) begin
                            e.x = X_W'(ox + c * scale + sx);
                            e.y = Y_W'(oy + r * scale + sy);
                            e.c = px ? f : b;
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
        x0 = X_W'(ox);
        y0 = Y_W'(oy);
        fg = f;
        bg = b;
        transparent = tr;
    endtask

    // Issue one draw and follow it cycle by cycle. stall_n holds wr_ack low
    // for that many cycles on the first write; abort_at asserts reset at
    // that busy cycle and checks the draw is dropped.
    task automatic run_draw(input string tag, input int stall_n, input int abort_at,
                            input int exp_busy, input int exp_done, input int exp_writes);
        int  k, busy_cyc, done_at, done_n, writes, stalled;
        wr_t snap, cur, e;
        wr_ack = (stall_n == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; busy_cyc = 0; done_at = -1; done_n = 0; writes = 0; stalled = 0;
        snap = '0;
        while (m_busy && k < 2000) begin
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check({tag, "_busy_after_reset"}, 32'(m_busy), 0);
                check({tag, "_wr_req_after_reset"}, 32'(m_wr_req), 0);
                check({tag, "_done_after_reset"}, 32'(m_done), 0);
                reset = 1'b0;
                check({tag, "_no_done_pulse"}, 32'(done_n), 0);
                exp_q.delete();
                wr_ack = 1'b1;
                return;
            end
            if (m_done) begin
                done_n++;
                done_at = k;
            end
            busy_cyc++;
            cur = {m_wr_x, m_wr_y, m_wr_color};
            if (m_wr_req && !wr_ack) begin
                if (stalled == 0) snap = cur;
                else check({tag, "_hold"}, 32'(cur), 32'(snap));
                if (stalled == stall_n) wr_ack = 1'b1;
                else stalled++;
            end
            if (m_wr_req && wr_ack) begin
                writes++;
                check({tag, "_write_expected"}, 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_write"}, 32'(cur), 32'(e));
                end
            end
            k++;
            @(negedge clk);
        end
        check({tag, "_terminated"}, 32'(k < 2000), 1);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
        check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, "_done_pulses"}, 32'(done_n), 1);
        check({tag, "_write_count"}, 32'(writes), 32'(exp_writes));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
        check({tag, "_idle_wr_req"}, 32'(m_wr_req), 0);
        wr_ack = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel = 1'b0; wr_ack = 1'b1;
        x0 = '0; y0 = '0; fg = '0; bg = '0; transparent = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_wr_req", 32'(wr_req1), 0);
        check("rst_rom_row", 32'(rom_row1), 0);
        check("rst_wr_x", 32'(wr_x1), 0);
        check("rst_wr_y", 32'(wr_y1), 0);
        check("rst_wr_color", 32'(wr_color1), 0);
        check("rst_busy2", 32'(busy2), 0);
        reset = 1'b0;
        @(negedge clk);

        push_draw(100, 50, 8'hFF, 8'h00, 1'b0, 1);
        run_draw("opaque", 0, 0, 31, 31, 25);

        push_draw(100, 50, 8'hFF, 8'h00, 1'b1, 1);
        run_draw("transp", 0, 0, 31, 31, 5);

        push_draw(100, 50, 8'hFF, 8'h00, 1'b0, 1);
        run_draw("stall", 3, 0, 34, 34, 25);

        sel = 1'b1;
        push_draw(0, 0, 8'hFF, 8'h00, 1'b0, 2);
        run_draw("scale2", 0, 0, 106, 106, 100);
        sel = 1'b0;

        push_draw(1022, 50, 8'hA5, 8'h3C, 1'b0, 1);
        run_draw("wrap", 0, 0, 31, 31, 25);

        push_draw(100, 50, 8'hFF, 8'h00, 1'b0, 1);
        run_draw("abort", 0, 15, 0, 0, 0);
        @(negedge clk);
        check("abort_idle_busy", 32'(busy1), 0);

        push_draw(200, 100, 8'h11, 8'h22, 1'b0, 1);
        run_draw("after_reset", 0, 0, 31, 31, 25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
